ir_sampler: RTL and testbench

Front-end for the NEC IR receive path. It synchronises the raw IR receiver output into the system clock domain and glitch-filters it. It then produces one phase-aligned sample per 0.5625 ms NEC slot, plus a slot-rate clock, which the downstream NEC frame decoder consumes. Sampling is re-centred on every falling edge of the filtered line so that each sample lands mid-slot.

---
 rtl/ir_pkg.sv | 15 +
 rtl/ir_glitch_filter.sv | 50 +++++
 rtl/ir_sampler.sv | 138 +++++++++++++
 tb/tb_ir_sampler.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// ir_pkg: shared constants and types for the NEC IR receive front-end.
// Slot timing defaults assume a 50 MHz system clock.
package ir_pkg;

  // 50 MHz / 28125 = 0.5625 ms, one NEC slot
  localparam int NEC_SLOT_DIV   = 28125;
  localparam int NEC_FILT_LEN   = 16;
  localparam int NEC_IDLE_SLOTS = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ir_state_t;

endpackage

// File: rtl/ir_glitch_filter.sv
// ir_glitch_filter: accepts a new level only after it has persisted
// FILT_LEN consecutive cycles; flags the falling edge being committed.
module ir_glitch_filter
  import ir_pkg::*;
#(
  parameter int FILT_LEN = NEC_FILT_LEN
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic fall
);

  localparam int CW = $clog2(FILT_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(FILT_LEN - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          lvl_q, lvl_d;

  // count cycles of disagreement; flip level on the FILT_LEN-th one
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    if (din != lvl_q) begin
      if (cnt_q == LAST) begin
        lvl_d = din;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // filter state, line idles high
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
      lvl_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      lvl_q <= lvl_d;
    end
  end

  assign dout = lvl_q;
  // high in the cycle before dout drops, so the edge is acted on
  // at the same clock that commits it
  assign fall = lvl_q & ~lvl_d;

endmodule

// File: rtl/ir_sampler.sv
// ir_sampler: synchronises and filters the IR line, then emits one
// mid-slot sample per NEC slot, re-centred on every filtered falling edge.
module ir_sampler
  import ir_pkg::*;
#(
  parameter int DIV        = NEC_SLOT_DIV,
  parameter int FILT_LEN   = NEC_FILT_LEN,
  parameter int IDLE_SLOTS = NEC_IDLE_SLOTS,
  parameter bit INVERT     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic ir_in,
  output logic ir_level,
  output logic sample_en,
  output logic sample,
  output logic ir_clk,
  output logic active
);

  localparam int CW = $clog2(DIV);
  localparam int SW = $clog2(IDLE_SLOTS + 1);
  localparam logic [CW-1:0] WRAP  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF  = CW'(DIV / 2);
  // chosen so the next strobe lands DIV/2 cycles after the edge
  localparam logic [CW-1:0] ALIGN = CW'(DIV - DIV / 2);
  localparam logic [SW-1:0] SLOT_LAST = SW'(IDLE_SLOTS - 1);

  logic ir_raw;
  logic sync1_q, sync2_q;
  logic fall;

  assign ir_raw = INVERT ? ~ir_in : ir_in;

  // two-flop synchroniser, preset to the idle level
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= ir_raw;
      sync2_q <= sync1_q;
    end
  end

  ir_glitch_filter #(
    .FILT_LEN (FILT_LEN)
  ) u_filt (
    .clk   (clk),
    .reset (reset),
    .din   (sync2_q),
    .dout  (ir_level),
    .fall  (fall)
  );

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick;
  logic          sample_en_q, sample_q, ir_clk_q;

  // realignment beats a wrap landing on the same cycle
  assign tick = (cnt_q == WRAP) && !fall;

  // next divider value
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (fall) begin
      cnt_d = ALIGN;
    end else if (cnt_q == WRAP) begin
      cnt_d = '0;
    end
  end

  // slot divider, strobe, sample capture and slot clock
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q       <= '0;
      sample_en_q <= 1'b0;
      sample_q    <= 1'b1;
      ir_clk_q    <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      sample_en_q <= tick;
      if (tick) begin
        sample_q <= ir_level;
      end
      ir_clk_q    <= (cnt_d < HALF);
    end
  end

  ir_state_t     state_q;
  logic [SW-1:0] slots_q;
  logic          active_q;

  // IDLE/RUN tracking: leave RUN after IDLE_SLOTS high samples in a row
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      slots_q  <= '0;
      active_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (fall) begin
            state_q  <= RUN;
            slots_q  <= '0;
            active_q <= 1'b1;
          end
        end
        RUN: begin
          if (fall) begin
            slots_q <= '0;
          end else if (tick) begin
            if (!ir_level) begin
              slots_q <= '0;
            end else if (slots_q == SLOT_LAST) begin
              state_q  <= IDLE;
              slots_q  <= '0;
              active_q <= 1'b0;
            end else begin
              slots_q <= slots_q + 1'b1;
            end
          end
        end
        default: begin
          state_q  <= IDLE;
          slots_q  <= '0;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign sample_en = sample_en_q;
  assign sample    = sample_q;
  assign ir_clk    = ir_clk_q;
  assign active    = active_q;

endmodule

// File: tb/tb_ir_sampler.sv
// tb_ir_sampler: randomized NEC-style stimulus on a plain and an
// inverted instance, scored against a slot-level reference model.
`timescale 1ns/1ps
module tb_ir_sampler;

  localparam int DIV = 40;
  localparam int D2  = DIV / 2;
  localparam int FL  = 4;
  localparam int IS  = 6;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ir = 1'b1;
  logic ir_n;
  assign ir_n = ~ir;

  logic lv0, en0, sm0, ck0, ac0;
  logic lv1, en1, sm1, ck1, ac1;

  ir_sampler #(.DIV(DIV), .FILT_LEN(FL), .IDLE_SLOTS(IS), .INVERT(1'b0)) dut (
    .clk(clk), .reset(reset), .ir_in(ir), .ir_level(lv0),
    .sample_en(en0), .sample(sm0), .ir_clk(ck0), .active(ac0)
  );

  ir_sampler #(.DIV(DIV), .FILT_LEN(FL), .IDLE_SLOTS(IS), .INVERT(1'b1)) dut_i (
    .clk(clk), .reset(reset), .ir_in(ir_n), .ir_level(lv1),
    .sample_en(en1), .sample(sm1), .ir_clk(ck1), .active(ac1)
  );

  always #10 clk = ~clk;

  typedef struct {
    int   cyc;
    logic smp;
    logic act;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // reference model state
  logic m_lvl = 1'b1;
  logic m_smp = 1'b1;
  logic m_act = 1'b0;
  int   m_run = 0;
  int   m_next = DIV;
  int   m_highs = 0;
  logic pipe[$];

  task automatic model_step();
    logic din, old, fell, fire;
    exp_t e;
    if (!reset) begin
      pipe.delete();
      pipe.push_back(1'b1);
      pipe.push_back(1'b1);
      m_lvl = 1'b1; m_smp = 1'b1; m_act = 1'b0;
      m_run = 0; m_highs = 0; m_next = cyc + DIV;
      return;
    end
    pipe.push_back(ir);
    din = pipe.pop_front();
    old = m_lvl;
    if (din != m_lvl) begin
      m_run++;
      if (m_run == FL) begin
        m_lvl = din;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    fell = old && !m_lvl;
    fire = 1'b0;
    if (fell) begin
      m_next = cyc + D2;
    end else if (cyc == m_next) begin
      fire = 1'b1;
      m_smp = old;
      m_next += DIV;
    end
    if (fell) begin
      m_act = 1'b1;
      m_highs = 0;
    end else if (fire && m_act) begin
      if (m_smp) begin
        m_highs++;
        if (m_highs == IS) begin
          m_act = 1'b0;
          m_highs = 0;
        end
      end else begin
        m_highs = 0;
      end
    end
    if (fire) begin
      e.cyc = cyc; e.smp = m_smp; e.act = m_act;
      q.push_back(e);
    end
  endtask

  initial begin
    pipe.push_back(1'b1);
    pipe.push_back(1'b1);
    forever begin
      @(posedge clk);
      cyc++;
      model_step();
    end
  end

  task automatic chk(string nm, logic act, logic req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cyc, act, req);
    end
  endtask

  task automatic chk_int(string nm, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, req);
    end
  endtask

  // monitor: pops the scoreboard whenever a strobe is due
  initial begin
    exp_t e;
    bit   exp_en;
    logic exp_ck;
    @(posedge clk);
    forever begin
      @(negedge clk);
      exp_en = (q.size() > 0) && (q[0].cyc == cyc);
      chk("sample_en", en0, exp_en);
      chk("sample_en_inv", en1, exp_en);
      if (exp_en) begin
        e = q.pop_front();
        chk("strobe_sample", sm0, e.smp);
        chk("strobe_active", ac0, e.act);
      end
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL stale_strobe due=%0d now=%0d", e.cyc, cyc);
      end
      exp_ck = ((DIV - (m_next - cyc)) < D2);
      chk("ir_level", lv0, m_lvl);
      chk("ir_level_inv", lv1, m_lvl);
      chk("sample", sm0, m_smp);
      chk("sample_inv", sm1, m_smp);
      chk("active", ac0, m_act);
      chk("active_inv", ac1, m_act);
      chk("ir_clk", ck0, exp_ck);
      chk("ir_clk_inv", ck1, exp_ck);
    end
  end

  task automatic hold(logic v, int n);
    ir = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic slots(logic v, int n);
    hold(v, n * DIV);
  endtask

  task automatic seg(logic v, int n, int jit, bit noise);
    int len, k, b;
    len = n * DIV + int'($urandom_range(0, 2 * jit)) - jit;
    if (noise && $urandom_range(0, 3) == 0) begin
      b = int'($urandom_range(1, FL - 1));
      k = int'($urandom_range(FL + 2, len - b - FL - 2));
      hold(v, k);
      hold(!v, b);
      hold(v, len - k - b);
    end else begin
      hold(v, len);
    end
  endtask

  task automatic send_frame(logic [7:0] a, logic [7:0] c, int jit, bit noise);
    logic [31:0] w;
    w = {~c, c, ~a, a};
    seg(1'b0, 16, jit, noise);
    seg(1'b1, 8, jit, noise);
    for (int i = 0; i < 32; i++) begin
      seg(1'b0, 1, jit, noise);
      seg(1'b1, w[i] ? 3 : 1, jit, noise);
    end
    seg(1'b0, 1, jit, noise);
  endtask

  initial begin
    int c0, fc, wt;
    bit found;
    reset = 1'b0;
    ir = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    slots(1'b1, 3);

    // leader: explicit latency check from the drive cycle
    c0 = cyc;
    ir = 1'b0;
    found = 1'b0;
    fc = 0;
    for (int k = 0; k < FL + 2 + D2 + 5; k++) begin
      @(negedge clk);
      if (en0 && !found) begin
        found = 1'b1;
        fc = cyc;
      end
    end
    chk_int("leader_first_strobe", found ? fc : -1, c0 + FL + 2 + D2);
    hold(1'b0, 16 * DIV - (FL + 2 + D2 + 5));
    slots(1'b1, 8);
    slots(1'b1, IS + 2);

    // short glitches on an idle line
    repeat (8) begin
      hold(1'b0, int'($urandom_range(1, FL - 1)));
      hold(1'b1, int'($urandom_range(FL + 2, 3 * DIV)));
    end

    // clean frame, then timeout
    send_frame(8'h00, 8'h45, 0, 1'b0);
    slots(1'b1, IS + 2);

    // falling edge landing just before, on and after a wrap
    for (int off = -1; off <= 1; off++) begin
      wt = 0;
      while ((m_next - cyc) != FL + 2 - off && wt < 2 * DIV) begin
        @(negedge clk);
        wt++;
      end
      if (wt >= 2 * DIV) begin
        n_cmp++;
        n_bad++;
        $display("FAIL align_wait off=%0d", off);
      end
      slots(1'b0, 2);
      slots(1'b1, IS + 2);
    end

    // reset in the middle of a frame
    slots(1'b0, 16);
    slots(1'b1, 8);
    slots(1'b0, 1);
    hold(1'b1, D2);
    ir = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    hold(1'b0, DIV);
    slots(1'b1, IS + 4);

    // jittered, noisy random frames
    repeat (4) begin
      send_frame(8'($urandom), 8'($urandom), 3, 1'b1);
      slots(1'b1, IS + 2);
      hold(1'b1, int'($urandom_range(0, DIV)));
    end

    repeat (10) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
